// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl
// Drives a DRV8833-style H-bridge (in_a/in_b: 10 fwd, 01 rev, 11 brake,
// 00 coast) from the PWM stage's spd/dir outputs. spd and dir come from a
// slower clock domain, so both are double-flop synchronised. dir is also
// debounced. Every direction reversal runs brake then dead-time, so the
// bridge never flips polarity while it is driven.
//
// Optional feature: define MOTOR_DRV_WDOG_EN to enable the stuck-high spd
// watchdog. This adds a fault flag that is cleared by i_clr_fault while in
// COAST. Without the macro, o_fault is tied 0 and i_clr_fault is ignored.
//
// Ports:
//   i_clk        system clock (5 MHz)
//   i_rst_n      asynchronous active-low reset
//   i_en         drive enable, level
//   i_spd        PWM from the PWM stage (asynchronous)
//   i_dir        direction from the PWM stage (asynchronous), 0=fwd 1=rev
//   i_clr_fault  fault clear pulse (watchdog build only)
//   o_in_a       H-bridge input A, registered
//   o_in_b       H-bridge input B, registered
//   o_state      FSM state: 00 COAST, 01 RUN, 10 BRAKE, 11 DEAD
//   o_dir_cur    direction currently applied to the bridge
//   o_fault      watchdog fault flag
module motor_drive_ctrl #(
  parameter int DEAD_CYC  = 50,
  parameter int BRAKE_CYC = 500,
  parameter int DIR_FILT  = 4,
  parameter int WDOG_CYC  = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_spd,
  input  logic       i_dir,
  input  logic       i_clr_fault,
  output logic       o_in_a,
  output logic       o_in_b,
  output logic [1:0] o_state,
  output logic       o_dir_cur,
  output logic       o_fault
);

  // Zero or negative cycle counts would make the sequence degenerate, so clamp them to 1.
  localparam int DEAD_EFF  = (DEAD_CYC  < 1) ? 1 : DEAD_CYC;
  localparam int BRAKE_EFF = (BRAKE_CYC < 1) ? 1 : BRAKE_CYC;
  localparam int FILT_EFF  = (DIR_FILT  < 1) ? 1 : DIR_FILT;
  localparam int WDOG_EFF  = (WDOG_CYC  < 1) ? 1 : WDOG_CYC;
  localparam int MAX_DB    = (DEAD_EFF > BRAKE_EFF) ? DEAD_EFF : BRAKE_EFF;
  localparam int MAX_ALL   = (MAX_DB > WDOG_EFF) ? MAX_DB : WDOG_EFF;
  localparam int CNT_W     = $clog2(MAX_ALL + 1);
  localparam int FILT_W    = $clog2(FILT_EFF + 1);

  localparam logic [CNT_W-1:0]  DEAD_LOAD  = CNT_W'(DEAD_EFF - 1);
  localparam logic [CNT_W-1:0]  BRAKE_LOAD = CNT_W'(BRAKE_EFF - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(FILT_EFF - 1);
  localparam logic [FILT_W-1:0] FILT_ONE   = FILT_W'(1);

  typedef enum logic [1:0] {
    COAST = 2'b00,
    RUN   = 2'b01,
    BRAKE = 2'b10,
    DEAD  = 2'b11
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [FILT_W-1:0] r_filtCnt;
  logic              r_spdMeta, r_spdS;
  logic              r_dirMeta, r_dirS;
  logic              r_dirReq;
  logic              r_dirCur;
  logic              r_inA, r_inB;
  logic              w_wdTrip;
  logic              w_faultBlock;

  // Two-flop synchronisers for the asynchronous spd and dir pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_spdMeta <= 1'b0;
      r_spdS    <= 1'b0;
      r_dirMeta <= 1'b0;
      r_dirS    <= 1'b0;
    end else begin
      r_spdMeta <= i_spd;
      r_spdS    <= r_spdMeta;
      r_dirMeta <= i_dir;
      r_dirS    <= r_dirMeta;
    end
  end

  // Debounce: dir_req only follows dir_s after FILT_EFF consecutive disagreeing cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filtCnt <= '0;
      r_dirReq  <= 1'b0;
    end else if (r_dirS == r_dirReq) begin
      r_filtCnt <= '0;
    end else if (r_filtCnt == FILT_LAST) begin
      r_dirReq  <= r_dirS;
      r_filtCnt <= '0;
    end else begin
      r_filtCnt <= r_filtCnt + FILT_ONE;
    end
  end

`ifdef MOTOR_DRV_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_EFF - 1);

  logic             r_spdPrev;
  logic [CNT_W-1:0] r_wdCnt;
  logic             r_fault;
  logic             w_spdHeld;

  // spd_s is high and did not change this cycle. A low spd_s never arms the watchdog.
  assign w_spdHeld    = r_spdS && (r_spdS == r_spdPrev);
  assign w_wdTrip     = (r_state == RUN) && w_spdHeld && (r_wdCnt == WDOG_LAST);
  assign w_faultBlock = r_fault;
  assign o_fault      = r_fault;

  // Watchdog: counts stuck-high cycles in RUN. The fault latches until it is cleared in COAST.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_spdPrev <= 1'b0;
      r_wdCnt   <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_spdPrev <= r_spdS;
      if ((r_state == RUN) && w_spdHeld) begin
        if (w_wdTrip) begin
          r_wdCnt <= '0;
          r_fault <= 1'b1;
        end else begin
          r_wdCnt <= r_wdCnt + CNT_ONE;
        end
      end else begin
        r_wdCnt <= '0;
      end
      if (r_fault && (r_state == COAST) && i_clr_fault) begin
        r_fault <= 1'b0;
      end
    end
  end
`else
  logic w_unused;

  assign w_wdTrip     = 1'b0;
  assign w_faultBlock = 1'b0;
  assign o_fault      = 1'b0;
  assign w_unused     = i_clr_fault;
`endif

  // Main sequencer. The bridge outputs are registered together with the state,
  // so every branch also sets the drive pattern for the state it enters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= COAST;
      r_cnt    <= '0;
      r_dirCur <= 1'b0;
      r_inA    <= 1'b0;
      r_inB    <= 1'b0;
    end else if (!i_en) begin
      r_state <= COAST;
      r_cnt   <= '0;
      r_inA   <= 1'b0;
      r_inB   <= 1'b0;
    end else begin
      case (r_state)
        COAST: begin
          r_inA <= 1'b0;
          r_inB <= 1'b0;
          if (!w_faultBlock) begin
            r_state <= DEAD;
            r_cnt   <= DEAD_LOAD;
          end
        end
        DEAD: begin
          if (r_cnt == '0) begin
            // Apply the latest filtered direction even if it equals the old one.
            r_dirCur <= r_dirReq;
            r_state  <= RUN;
            r_inA    <= r_spdS & ~r_dirReq;
            r_inB    <= r_spdS &  r_dirReq;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
            r_inA <= 1'b0;
            r_inB <= 1'b0;
          end
        end
        RUN: begin
          if (w_wdTrip) begin
            r_state <= COAST;
            r_inA   <= 1'b0;
            r_inB   <= 1'b0;
          end else if (r_dirReq != r_dirCur) begin
            r_state <= BRAKE;
            r_cnt   <= BRAKE_LOAD;
            r_inA   <= 1'b1;
            r_inB   <= 1'b1;
          end else begin
            r_inA <= r_spdS & ~r_dirCur;
            r_inB <= r_spdS &  r_dirCur;
          end
        end
        BRAKE: begin
          if (r_cnt == '0) begin
            r_state <= DEAD;
            r_cnt   <= DEAD_LOAD;
            r_inA   <= 1'b0;
            r_inB   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
            r_inA <= 1'b1;
            r_inB <= 1'b1;
          end
        end
        default: begin
          r_state <= COAST;
          r_inA   <= 1'b0;
          r_inB   <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_a    = r_inA;
  assign o_in_b    = r_inB;
  assign o_state   = r_state;
  assign o_dir_cur = r_dirCur;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// tb_motor_drive_ctrl
// Scoreboard bench for motor_drive_ctrl (default build, watchdog disabled).
// The stimulus side drives the pins on the falling clock edge. It then steps a
// behavioural model of the drive sequence, written in terms of absolute
// phase-end times and sample windows, and queues the expected outputs for the
// next rising edge. A separate monitor pops and compares just after each
// rising edge.
`timescale 1ns/1ps
module tb_motor_drive_ctrl;

  localparam int DEAD_CYC  = 50;
  localparam int BRAKE_CYC = 500;
  localparam int DIR_FILT  = 4;
  localparam int WDOG_CYC  = 100000;

  localparam logic [1:0] ST_COAST = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_BRAKE = 2'b10;
  localparam logic [1:0] ST_DEAD  = 2'b11;

  typedef struct {
    logic       inA;
    logic       inB;
    logic [1:0] st;
    logic       dirCur;
    logic       fault;
  } expT;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       spd;
  logic       dir;
  logic       clrFault;
  logic       inA;
  logic       inB;
  logic [1:0] state;
  logic       dirCur;
  logic       fault;

  int  testsRun    = 0;
  int  testsFailed = 0;
  int  spdCnt      = 0;
  expT sbQ[$];
  expT lastExp;

  // Behavioural model state
  int         mCyc;
  logic [1:0] mPhase;
  int         mPhaseEnd;
  logic       mDirCur;
  logic       mDirReq;
  logic       spdLine[$];
  logic       dirLine[$];
  logic       filtWin[$];

  motor_drive_ctrl #(
    .DEAD_CYC (DEAD_CYC),
    .BRAKE_CYC(BRAKE_CYC),
    .DIR_FILT (DIR_FILT),
    .WDOG_CYC (WDOG_CYC)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_spd      (spd),
    .i_dir      (dir),
    .i_clr_fault(clrFault),
    .o_in_a     (inA),
    .o_in_b     (inB),
    .o_state    (state),
    .o_dir_cur  (dirCur),
    .o_fault    (fault)
  );

  // 5 MHz system clock
  initial clk = 1'b0;
  always #100 clk = ~clk;

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    mCyc      = 0;
    mPhase    = ST_COAST;
    mPhaseEnd = 0;
    mDirCur   = 1'b0;
    mDirReq   = 1'b0;
    spdLine   = '{1'b0, 1'b0};
    dirLine   = '{1'b0, 1'b0};
    filtWin.delete();
  endtask

  // One rising edge of the model. Index 1 of each line is the pin value from
  // two edges back, i.e. what the synchronised signal holds before this edge.
  task automatic modelStep(input logic enIn, input logic spdIn, input logic dirIn, output expT e);
    logic spdS;
    logic dirS;
    logic allDiff;
    spdS = spdLine[1];
    dirS = dirLine[1];

    if (!enIn) begin
      mPhase = ST_COAST;
    end else begin
      case (mPhase)
        ST_COAST: begin
          mPhase    = ST_DEAD;
          mPhaseEnd = mCyc + DEAD_CYC;
        end
        ST_DEAD: begin
          if (mCyc == mPhaseEnd) begin
            mDirCur = mDirReq;
            mPhase  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (mDirReq != mDirCur) begin
            mPhase    = ST_BRAKE;
            mPhaseEnd = mCyc + BRAKE_CYC;
          end
        end
        default: begin
          if (mCyc == mPhaseEnd) begin
            mPhase    = ST_DEAD;
            mPhaseEnd = mCyc + DEAD_CYC;
          end
        end
      endcase
    end

    e.st     = mPhase;
    e.dirCur = mDirCur;
    e.fault  = 1'b0;
    e.inA    = (mPhase == ST_BRAKE) || ((mPhase == ST_RUN) && spdS && !mDirCur);
    e.inB    = (mPhase == ST_BRAKE) || ((mPhase == ST_RUN) && spdS && mDirCur);

    // The direction request flips once the last DIR_FILT synced samples all disagree with it.
    filtWin.push_back(dirS);
    if (filtWin.size() > DIR_FILT) void'(filtWin.pop_front());
    if (filtWin.size() == DIR_FILT) begin
      allDiff = 1'b1;
      foreach (filtWin[i]) if (filtWin[i] == mDirReq) allDiff = 1'b0;
      if (allDiff) begin
        mDirReq = ~mDirReq;
        filtWin.delete();
      end
    end

    spdLine.push_front(spdIn);
    void'(spdLine.pop_back());
    dirLine.push_front(dirIn);
    void'(dirLine.pop_back());
    mCyc++;
  endtask

  // Called at a falling edge: drive pins, queue the expected response, and wait for the next falling edge.
  task automatic applyStimulus(input logic enIn, input logic spdIn, input logic dirIn);
    expT e;
    en       = enIn;
    spd      = spdIn;
    dir      = dirIn;
    clrFault = 1'b0;
    modelStep(enIn, spdIn, dirIn, e);
    sbQ.push_back(e);
    lastExp = e;
    @(negedge clk);
  endtask

  // 25% duty square on spd (12 clk period approximates the 400 kHz PWM)
  task automatic runSquare(input int n, input logic enIn, input logic dirIn);
    for (int i = 0; i < n; i++) begin
      applyStimulus(enIn, (spdCnt % 12) < 3, dirIn);
      spdCnt++;
    end
  endtask

  // Reset asserted between clock edges; outputs must clear without any clock edge.
  task automatic asyncReset(input string tag);
    expT z;
    #20 rst_n = 1'b0;
    #1;
    checkOutput({tag, "_in_a"},    inA,    2'd0);
    checkOutput({tag, "_in_b"},    inB,    2'd0);
    checkOutput({tag, "_state"},   state,  2'd0);
    checkOutput({tag, "_dir_cur"}, dirCur, 2'd0);
    checkOutput({tag, "_fault"},   fault,  2'd0);
    modelReset();
    z.inA = 1'b0; z.inB = 1'b0; z.st = ST_COAST; z.dirCur = 1'b0; z.fault = 1'b0;
    sbQ.push_back(z);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every queued expectation just after the rising edge it describes.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("in_a",    inA,    e.inA);
        checkOutput("in_b",    inB,    e.inB);
        checkOutput("state",   state,  e.st);
        checkOutput("dir_cur", dirCur, e.dirCur);
        checkOutput("fault",   fault,  e.fault);
      end
    end
  end

  initial begin
    bit found;
    rst_n    = 1'b1;
    en       = 1'b0;
    spd      = 1'b0;
    dir      = 1'b0;
    clrFault = 1'b0;
    modelReset();
    lastExp.inA = 1'b0; lastExp.inB = 1'b0; lastExp.st = ST_COAST;
    lastExp.dirCur = 1'b0; lastExp.fault = 1'b0;

    // Power-on reset
    #10 rst_n = 1'b0;
    #40;
    checkOutput("por_in_a",    inA,    2'd0);
    checkOutput("por_in_b",    inB,    2'd0);
    checkOutput("por_state",   state,  2'd0);
    checkOutput("por_dir_cur", dirCur, 2'd0);
    checkOutput("por_fault",   fault,  2'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Enable, forward: dead-time then run following spd
    runSquare(120, 1'b1, 1'b0);
    // Reversal: brake, dead-time, run in reverse
    runSquare(620, 1'b1, 1'b1);
    // Glitch of DIR_FILT-1 cycles must be ignored
    runSquare(20, 1'b1, 1'b1);
    runSquare(DIR_FILT - 1, 1'b1, 1'b0);
    runSquare(40, 1'b1, 1'b1);
    // Glitch of exactly DIR_FILT cycles is accepted and reverses again
    runSquare(DIR_FILT, 1'b1, 1'b0);
    runSquare(620, 1'b1, 1'b1);
    // Reverse, drop en about 100 clk into brake, then re-enable
    runSquare(106, 1'b1, 1'b0);
    runSquare(3, 1'b0, 1'b0);
    runSquare(120, 1'b1, 1'b0);

    // Randomised segments: random spd, random dir holds, occasional en drops
    for (int s = 0; s < 300; s++) begin
      logic segEn;
      logic segDir;
      int   segLen;
      segEn  = ($urandom_range(0, 19) != 0);
      segDir = 1'($urandom_range(0, 1));
      segLen = $urandom_range(1, 10);
      for (int i = 0; i < segLen; i++) applyStimulus(segEn, 1'($urandom_range(0, 1)), segDir);
    end

    // Get back into RUN with in_a driven, then reset asynchronously
    found = 1'b0;
    for (int i = 0; i < 1500 && !found; i++) begin
      runSquare(1, 1'b1, 1'b0);
      found = (lastExp.st == ST_RUN) && lastExp.inA;
    end
    checkOutput("reach_run_in_a", {1'b0, found}, 2'd1);
    if (found) begin
      @(negedge clk);
      asyncReset("midrun");
    end
    runSquare(80, 1'b1, 1'b0);

    checkOutput("scoreboard_drained", {1'b0, sbQ.size() == 0}, 2'd1);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/motor_drive_ctrl.md
Name: motor_drive_ctrl

Overview:
- Downstream of the PWM stage: consumes its spd (PWM) and dir outputs and drives the two H-bridge inputs (in_a/in_b, DRV8833-style: 10 fwd, 01 rev, 11 brake, 00 coast).
- Synchronises both inputs and debounces dir.
- Sequences brake then dead-time on every direction reversal so the bridge never flips polarity while driven.
- Runs on the 5 MHz system clock. spd/dir arrive from the 400 kHz domain and are treated as asynchronous.

Parameters:
- DEAD_CYC, 50, coast cycles inserted before driving (values <1 treated as 1)
- BRAKE_CYC, 500, brake cycles on direction reversal (values <1 treated as 1)
- DIR_FILT, 4, consecutive cycles a dir change must persist before it is accepted
- WDOG_CYC, 100000, watchdog limit in cycles of spd held high with no edge (optional feature only)

Ports:
- clk  in  1  system clock, 5 MHz
- rst_n  in  1  asynchronous active-low reset
- en  in  1  drive enable, synchronous, level
- spd  in  1  PWM from PWM stage, async
- dir  in  1  direction from PWM stage, async, 0=fwd 1=rev
- clr_fault  in  1  fault clear pulse
- in_a  out  1  H-bridge input A, registered
- in_b  out  1  H-bridge input B, registered
- state  out  2  FSM state: 00 COAST, 01 RUN, 10 BRAKE, 11 DEAD
- dir_cur  out  1  direction currently applied
- fault  out  1  watchdog fault flag

Behaviour:
- Reset (async assert, sync release): state=COAST, in_a=in_b=0, dir_cur=0, fault=0, all sync flops and counters 0.
- spd and dir each pass through a 2-flop synchroniser, giving spd_s and dir_s.
- Dir filter: a counter increments while dir_s != dir_req.
  - At DIR_FILT consecutive cycles, dir_req <= dir_s.
  - Any cycle with dir_s == dir_req zeroes the counter.
  - dir_req resets to 0.
- Outputs are registered. Latency from a spd pin edge to in_a/in_b in RUN is 3 clk (2 sync + 1 out).
- COAST: in_a=in_b=0. If en=1 and fault=0: load cnt=DEAD_CYC-1 and go to DEAD.
- DEAD: in_a=in_b=0. cnt decrements; when cnt==0:
  - dir_cur <= dir_req (latest filtered value);
  - go to RUN if en=1, else COAST.
- RUN: in_a = spd_s & ~dir_cur; in_b = spd_s & dir_cur. If dir_req != dir_cur: load cnt=BRAKE_CYC-1 and go to BRAKE.
- BRAKE: in_a=in_b=1. cnt decrements; at 0, load cnt=DEAD_CYC-1 and go to DEAD.
- en=0 in any state: go to COAST next cycle and abort the count. This has priority over all other transitions except reset.
- Reversal back during BRAKE/DEAD: the sequence still completes. dir_cur takes dir_req at DEAD exit, even if it equals the old direction.
- Filter glitch shorter than DIR_FILT cycles: no state change, no brake.
- Counter width is clog2(max(DEAD_CYC, BRAKE_CYC, WDOG_CYC)+1).
- Reset asserted mid-BRAKE/DEAD/RUN: outputs go to 00 immediately and asynchronously.

Optional Feature:
- Macro: MOTOR_DRV_WDOG_EN.
- Defined: in RUN, a separate counter counts cycles since the last spd_s edge while spd_s=1.
  - Reaching WDOG_CYC: fault <= 1 and go to COAST next cycle.
  - spd_s stuck low (0% duty) never faults.
  - fault holds until clr_fault=1 while in COAST.
  - Re-entry to DEAD requires fault=0.
- Undefined: watchdog logic absent, fault tied 0, clr_fault ignored.

Test Plan:
- Reset then en=1, dir=0, spd 25% square at 400 kHz → state 00→11 for 50 clk→01. in_a follows spd delayed 3 clk; in_b=0.
- In RUN, dir 0→1 held steady → after 2+4 clk state=10, in_a=in_b=1 for 500 clk. Then state=11, outputs 00 for 50 clk. Then RUN with dir_cur=1, in_b following spd.
- dir glitch of 3 clk (DIR_FILT=4) in RUN → no BRAKE, dir_cur stays 0, outputs uninterrupted.
- en dropped 100 clk into BRAKE → next clk state=00, outputs 00. Re-raise en → DEAD 50 clk then RUN with the filtered dir.
- rst_n pulsed low mid-RUN while in_a=1 → in_a=in_b=0 with no clk edge, all state 0.
- (MOTOR_DRV_WDOG_EN, WDOG_CYC=1000) spd held high 1000 clk → fault=1, state=00. clr_fault pulse → fault=0 and restart via DEAD.
